// File: rtl/bram_stream_reader.sv
// Streams len consecutive BRAM words from base_addr onto a valid/ready port,
// hiding the 1-cycle read latency behind a small registered FIFO.
module bram_stream_reader #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 192,
  parameter int DEPTH      = 2048,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic                  bram_re,
  output logic [ADDR_WIDTH-1:0] bram_rd_addr,
  input  logic [DATA_WIDTH-1:0] bram_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, addr_q;
  logic [ADDR_WIDTH:0]   len_q, issued_q, delivered_q, last_idx;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic [CW:0]           occ;
  logic                  pop, push;

  assign last_idx  = len_q - {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign out_last  = out_valid && (delivered_q == last_idx);
  assign busy      = (state_q == RUN);
  assign done      = (state_q == FINISH);
  assign pop       = out_valid & out_ready;
  assign push      = inflight_q;

  // Occupancy seen by the issue logic counts the read still in the RAM pipe,
  // so a new read is only launched when its word is guaranteed a slot.
  always_comb begin
    occ = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
    bram_re = (state_q == RUN) && (issued_q < len_q) &&
              (occ < (CW+1)'(BUF_DEPTH));
    bram_rd_addr = bram_re ? (base_q + issued_q[ADDR_WIDTH-1:0]) : addr_q;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    case (state_q)
      IDLE:    if (start) state_d = (len != '0) ? RUN : FINISH;
      RUN:     if (pop && (delivered_q == last_idx)) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      inflight_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      inflight_q <= bram_re;
      if (state_q == IDLE && start && len != '0) begin
        base_q      <= base_addr;
        len_q       <= len;
        issued_q    <= '0;
        delivered_q <= '0;
      end
      if (bram_re) begin
        issued_q <= issued_q + 1'b1;
        addr_q   <= bram_rd_addr;
      end
      if (push) begin
        mem_q[wr_ptr_q] <= bram_rd_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q    <= rd_ptr_q + 1'b1;
        delivered_q <= delivered_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a registered-read BRAM model.
module tb_bram_stream_reader;
  localparam int AW = 11;
  localparam int DW = 192;
  localparam int DEPTH = 2048;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy, done, bram_re, out_valid, out_ready, out_last;
  logic [AW-1:0] bram_rd_addr;
  logic [DW-1:0] bram_rd_data, out_data;

  bram_stream_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .bram_re(bram_re), .bram_rd_addr(bram_rd_addr),
    .bram_rd_data(bram_rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) bram_rd_data <= bram_re ? ram[bram_rd_addr] : '0;

  function automatic logic [DW-1:0] wexp(input int a);
    return {96'(a) ^ 96'h5A5A_0000, 96'(a)};
  endfunction

  int npass = 0, ntot = 0;

  logic [AW-1:0] addrs[$];
  logic [DW-1:0] datas[$];
  logic          lasts[$];
  int            beat_cyc[$];
  int first_re, first_vld, done_cyc, done_cnt, done_busy, busy_gap;
  int stall_err, max_occ, timeout, vld_seen;

  task automatic run_xfer(input logic [AW-1:0] b, input logic [AW:0] l,
                          input int mode, input int spurious, input int limit);
    int iss_tot, pop_tot, cyc;
    logic have_stall;
    logic [DW-1:0] stall_data;
    addrs.delete(); datas.delete(); lasts.delete(); beat_cyc.delete();
    first_re = -1; first_vld = -1; done_cyc = -1; done_cnt = 0; done_busy = 0;
    busy_gap = 0; stall_err = 0; max_occ = 0; timeout = 0; vld_seen = 0;
    iss_tot = 0; pop_tot = 0; have_stall = 1'b0; stall_data = '0;
    @(negedge clk);
    start = 1'b1; base_addr = b; len = l; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; base_addr = b + 11'h333; len = 12'd7;
    cyc = 0;
    forever begin
      out_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      if (spurious != 0 && (cyc == 1 || cyc == 4)) begin
        start = 1'b1; base_addr = 11'h100; len = 12'd3;
      end else start = 1'b0;
      #1;
      if (iss_tot - pop_tot > max_occ) max_occ = iss_tot - pop_tot;
      if (have_stall && out_valid && out_data !== stall_data) stall_err++;
      have_stall = out_valid && !out_ready;
      stall_data = out_data;
      if (bram_re) begin
        addrs.push_back(bram_rd_addr); iss_tot++;
        if (first_re < 0) first_re = cyc;
      end
      if (out_valid) begin
        vld_seen++;
        if (first_vld < 0) first_vld = cyc;
      end
      if (out_valid && out_ready) begin
        datas.push_back(out_data); lasts.push_back(out_last);
        beat_cyc.push_back(cyc); pop_tot++;
      end
      if (done) begin
        done_cnt++;
        if (busy) done_busy++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc < 0 && !busy && !done) busy_gap++;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      if (cyc >= limit) begin timeout = 1; break; end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; out_ready = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    ntot++; if ({busy, done, bram_re, out_valid, out_last} !== 5'b0)
      $display("FAIL reset_ctrl got %b want 00000", {busy, done, bram_re, out_valid, out_last}); else npass++;
    ntot++; if (bram_rd_addr !== '0) $display("FAIL reset_addr got %h want 0", bram_rd_addr); else npass++;
    ntot++; if (out_data !== '0) $display("FAIL reset_data got %h want 0", out_data); else npass++;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int err;
    run_xfer(11'h010, 12'd4, 0, 0, 50);
    ntot++; if (timeout != 0) $display("FAIL basic_timeout got %0d want 0", timeout); else npass++;
    ntot++; if (datas.size() != 4) $display("FAIL basic_count got %0d want 4", datas.size()); else npass++;
    err = 0;
    foreach (datas[k]) if (datas[k] !== wexp(16 + k) || lasts[k] !== (k == 3)) err++;
    ntot++; if (err != 0) $display("FAIL basic_beats got %0d bad want 0", err); else npass++;
    ntot++; if (first_re != 0 || addrs[0] !== 11'h010)
      $display("FAIL basic_first_read got cyc %0d want 0", first_re); else npass++;
    ntot++; if (first_vld != 2) $display("FAIL basic_latency got %0d want 2", first_vld); else npass++;
    ntot++; if (beat_cyc.size() != 4 || beat_cyc[3] != 5)
      $display("FAIL basic_throughput got last beat cyc %0d want 5", beat_cyc.size() == 4 ? beat_cyc[3] : -1); else npass++;
    ntot++; if (done_cyc != 6 || done_cnt != 1)
      $display("FAIL basic_done got cyc %0d cnt %0d want 6 1", done_cyc, done_cnt); else npass++;
    ntot++; if (busy_gap != 0 || done_busy != 0)
      $display("FAIL basic_busy got gap %0d overlap %0d want 0 0", busy_gap, done_busy); else npass++;
  endtask

  task automatic test_backpressure();
    int err;
    run_xfer(11'h000, 12'd8, 1, 0, 200);
    err = 0;
    if (datas.size() != 8) err++;
    foreach (datas[k]) if (datas[k] !== wexp(k) || lasts[k] !== (k == 7)) err++;
    ntot++; if (err != 0 || timeout != 0)
      $display("FAIL bp_beats got %0d bad (%0d beats) want 0", err, datas.size()); else npass++;
    ntot++; if (max_occ > 2) $display("FAIL bp_occupancy got %0d want <=2", max_occ); else npass++;
    ntot++; if (stall_err != 0) $display("FAIL bp_stable got %0d changes want 0", stall_err); else npass++;
    ntot++; if (done_cnt != 1) $display("FAIL bp_done got %0d want 1", done_cnt); else npass++;
  endtask

  task automatic test_wrap();
    int err;
    logic [AW-1:0] ea [4];
    ea[0] = 11'h7FE; ea[1] = 11'h7FF; ea[2] = 11'h000; ea[3] = 11'h001;
    run_xfer(11'h7FE, 12'd4, 0, 0, 50);
    err = 0;
    if (addrs.size() != 4) err++;
    foreach (addrs[k]) if (k < 4 && addrs[k] !== ea[k]) err++;
    ntot++; if (err != 0) $display("FAIL wrap_addr got %0d bad want 0", err); else npass++;
    err = 0;
    if (datas.size() != 4) err++;
    foreach (datas[k]) if (k < 4 && (datas[k] !== wexp(int'(ea[k])) || lasts[k] !== (k == 3))) err++;
    ntot++; if (err != 0) $display("FAIL wrap_beats got %0d bad want 0", err); else npass++;
  endtask

  task automatic test_len0();
    run_xfer(11'h123, 12'd0, 0, 0, 20);
    ntot++; if (addrs.size() != 0 || vld_seen != 0)
      $display("FAIL len0_quiet got re %0d vld %0d want 0 0", addrs.size(), vld_seen); else npass++;
    ntot++; if (done_cnt != 1 || done_cyc != 0)
      $display("FAIL len0_done got cnt %0d cyc %0d want 1 0", done_cnt, done_cyc); else npass++;
  endtask

  task automatic test_len_full();
    int aerr, derr;
    run_xfer(11'h005, 12'd2048, 0, 0, 3000);
    aerr = 0; derr = 0;
    foreach (addrs[k]) if (addrs[k] !== AW'((5 + k) % DEPTH)) aerr++;
    foreach (datas[k]) if (datas[k] !== wexp((5 + k) % DEPTH) || lasts[k] !== (k == 2047)) derr++;
    ntot++; if (datas.size() != 2048 || addrs.size() != 2048 || timeout != 0)
      $display("FAIL full_count got %0d beats %0d reads want 2048", datas.size(), addrs.size()); else npass++;
    ntot++; if (aerr != 0 || addrs.size() == 0 || addrs[addrs.size()-1] !== 11'h004)
      $display("FAIL full_addr got %0d bad want 0 ending at 004", aerr); else npass++;
    ntot++; if (derr != 0) $display("FAIL full_beats got %0d bad want 0", derr); else npass++;
  endtask

  task automatic test_reset_mid();
    int beats, dn;
    @(negedge clk);
    start = 1'b1; base_addr = 11'h020; len = 12'd10; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    beats = 0;
    for (int c = 0; c < 40 && beats < 3; c++) begin
      #1;
      if (out_valid && out_ready) beats++;
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk); #1;
    ntot++; if ({busy, done, bram_re, out_valid, out_last} !== 5'b0 || bram_rd_addr !== '0 || out_data !== '0)
      $display("FAIL midrst_outputs got %b addr %h want zeros", {busy, done, bram_re, out_valid, out_last}, bram_rd_addr); else npass++;
    rst_n = 1'b1;
    dn = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (done || busy || out_valid || bram_re) dn++;
    end
    ntot++; if (dn != 0) $display("FAIL midrst_idle got %0d active cycles want 0", dn); else npass++;
    run_xfer(11'h040, 12'd1, 0, 0, 30);
    ntot++; if (datas.size() != 1 || datas[0] !== wexp(64) || lasts[0] !== 1'b1 || done_cnt != 1)
      $display("FAIL midrst_restart got %0d beats done %0d want 1 1", datas.size(), done_cnt); else npass++;
  endtask

  task automatic test_start_while_busy();
    int err;
    run_xfer(11'h300, 12'd6, 0, 1, 60);
    err = 0;
    if (datas.size() != 6) err++;
    foreach (datas[k]) if (datas[k] !== wexp(12'h300 + k) || lasts[k] !== (k == 5)) err++;
    ntot++; if (err != 0 || done_cnt != 1)
      $display("FAIL busy_start got %0d bad done %0d want 0 1", err, done_cnt); else npass++;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = wexp(i);
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_len0();
    test_len_full();
    test_reset_mid();
    test_start_while_busy();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- Read-side controller for the on-chip block RAM buffers (default 2048 x 192-bit).
- On a start command it reads `len` consecutive words from `base_addr`, absorbs the RAM's 1-cycle registered read latency, and presents the words on a valid/ready stream with last-beat marking.
- Sits between a BRAM read port and downstream compute that may apply backpressure.

Parameters:
- ADDR_WIDTH, 11, BRAM address width.
- DATA_WIDTH, 192, BRAM word width.
- DEPTH, 2048, BRAM depth; must equal 2^ADDR_WIDTH.
- BUF_DEPTH, 2, output buffer entries; power of two, >= 2.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  command strobe; sampled only in IDLE.
- base_addr  input  ADDR_WIDTH  first read address.
- len  input  ADDR_WIDTH+1  word count, 0..DEPTH.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse at transfer completion.
- bram_re  output  1  BRAM read enable.
- bram_rd_addr  output  ADDR_WIDTH  BRAM read address.
- bram_rd_data  input  DATA_WIDTH  BRAM read data; valid the cycle after bram_re, zero otherwise.
- out_valid  output  1  stream valid.
- out_ready  input  1  stream ready.
- out_data  output  DATA_WIDTH  stream data.
- out_last  output  1  marks the final beat of a transfer.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - busy, done, bram_re, out_valid, out_last = 0; bram_rd_addr, out_data = 0.
  - Buffer and all counters cleared; state = IDLE.
  - Applies mid-transfer too: outstanding reads and buffered words are discarded and no done pulse is produced.
- States: IDLE, RUN, FINISH.
- IDLE, start=1, len>0:
  - Latch base_addr and len; issue counter = 0, delivered counter = 0; go to RUN.
- IDLE, start=1, len=0:
  - Go to FINISH; no BRAM access, no stream beat.
- start outside IDLE: ignored.
- RUN, read issue:
  - Define inflight = 1 if bram_re was high last cycle, else 0; pop = out_valid & out_ready.
  - bram_re = 1 when issued < len and (count + inflight - pop) < BUF_DEPTH. The issue decision is combinational from the registered count/inflight plus out_ready.
  - bram_rd_addr = (base + issued) mod DEPTH, i.e. natural ADDR_WIDTH wrap.
  - issued increments on each bram_re.
  - When bram_re=0, bram_rd_addr holds its last value.
- Capture:
  - When inflight=1, bram_rd_data is written into the buffer tail that cycle.
  - Data is never sampled when inflight=0, because the RAM returns 0 then.
- Output:
  - Buffer is FIFO-ordered and registered; out_valid = (count > 0).
  - out_data and out_last come from the buffer head and are stable while out_valid=1 and out_ready=0.
  - Simultaneous push and pop leaves count unchanged.
  - out_last = 1 on the word whose delivered index = len-1.
- RUN -> FINISH: when the last-word handshake occurs (delivered reaches len).
- FINISH: done = 1 for exactly one cycle, busy = 0 in that cycle; next state IDLE. A start in the cycle after FINISH is accepted.
- Latency, out_ready held high:
  - start sampled at edge T0 -> bram_re=1 with addr=base during T0..T1 -> word captured at edge T2 -> out_valid=1 from T2.
  - Sustained throughput is 1 word/cycle.
  - done is high in the cycle after the last handshake.
- Backpressure:
  - Buffer never overflows, because reads are issued only against free capacity including the inflight read.
  - With out_ready=0, at most BUF_DEPTH words are read ahead, then bram_re stays 0.
- len = DEPTH reads every address exactly once, wrapping from DEPTH-1 to 0.

Test Plan:
- Basic: base=0x010, len=4, RAM[i]=i, out_ready=1 -> beats 0x10..0x13 on consecutive cycles; out_last on 0x13; done one cycle later; busy high throughout.
- Backpressure: base=0, len=8, out_ready toggles 1,0,0,1,... -> all 8 words in order, no duplicate or missing word. Buffer count never exceeds 2. out_data stable while stalled.
- Wrap: base=0x7FE, len=4 -> addresses 0x7FE, 0x7FF, 0x000, 0x001 in order; out_last on the 4th beat.
- Edge lengths: len=0 -> done pulse, bram_re and out_valid never assert. len=2048, base=5 -> 2048 beats, last address 0x004.
- Reset mid-transfer: rst_n=0 after the 3rd beat of a len=10 transfer -> next cycle all outputs 0, state IDLE, no done. A new start with len=1 then works normally.
- start while busy: start pulses during RUN with different base/len -> ignored; the original transfer completes unchanged.
